// File: rtl/csa_seq_add_ctrl_pkg.sv
// Shared ALU definitions: controller state encoding and adder slice width.
package csa_seq_add_ctrl_pkg;

    localparam int unsigned SLICE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/csa_8_bits.sv
// 8-bit carry-select adder slice: ripple low half, upper half precomputed for both carries.
module csa_8_bits
    import csa_seq_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int unsigned H = SLICE_W / 2;

    logic [H:0] lo;
    logic [H:0] hi0;
    logic [H:0] hi1;

    assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
    assign hi0 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]};
    assign hi1 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]} + {{H{1'b0}}, 1'b1};

    // Low-half carry only selects between the two precomputed upper results.
    assign {cout, sum} = lo[H] ? {hi1, lo[H-1:0]} : {hi0, lo[H-1:0]};

endmodule

// File: rtl/csa_seq_add_ctrl.sv
// Wide add/subtract sequencer reusing one 8-bit carry-select slice, one byte per cycle, LSB first.
module csa_seq_add_ctrl
    import csa_seq_add_ctrl_pkg::*;
#(
    parameter  int unsigned NBYTES = 4,
    localparam int unsigned W      = SLICE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned        IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NBYTES - 1);

    state_e                          state_q;
    logic [NBYTES-1:0][SLICE_W-1:0]  a_q;
    logic [NBYTES-1:0][SLICE_W-1:0]  b_q;
    logic [NBYTES-1:0][SLICE_W-1:0]  sum_q;
    logic [IDX_W-1:0]                idx_q;
    logic                            carry_q;
    logic                            c_out_q;
    logic                            ovf_q;
    logic                            out_valid_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // b_q already holds the inverted operand for subtraction.
    assign slice_a = a_q[idx_q];
    assign slice_b = b_q[idx_q];

    csa_8_bits u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : c_in;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[idx_q] <= slice_sum;
                    carry_q      <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        c_out_q     <= slice_cout;
                        // Operand signs agree but the result sign differs.
                        ovf_q       <= (slice_a[SLICE_W-1] == slice_b[SLICE_W-1]) &&
                                       (slice_sum[SLICE_W-1] != slice_a[SLICE_W-1]);
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_csa_seq_add_ctrl.sv
// Bench for csa_seq_add_ctrl: directed and random operations against an arithmetic reference model.
module tb_csa_seq_add_ctrl;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         c_in;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_seq_add_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference: unsigned arithmetic for sum/carry, signed range test for overflow.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, input logic mci,
                                  output logic [W-1:0] es, output logic ec, output logic eo);
        logic [W:0] full;
        longint     sr;
        longint     smax;
        longint     smin;
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (ms) begin
            es = ma - mb;
            ec = (ma >= mb);
            sr = longint'($signed(ma)) - longint'($signed(mb));
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mci};
            es   = full[W-1:0];
            ec   = full[W];
            sr   = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mci);
        end
        eo = (sr > smax) || (sr < smin);
    endfunction

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          input logic tci, input int hold, input string name);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           cycles;
        model(ta, tb, ts, tci, es, ec, eo);
        a = ta; b = tb; sub = ts; c_in = tci; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); c_in = 1'($urandom);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checks++;
        if (cycles != NBYTES) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cycles, NBYTES);
        end
        checks++;
        if (sum !== es || c_out !== ec || ovf !== eo) begin
            errors++;
            $display("FAIL %s result: got sum=%h c_out=%b ovf=%b want sum=%h c_out=%b ovf=%b",
                     name, sum, c_out, ovf, es, ec, eo);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready in done: got %b want 0", name, in_ready);
        end
        if (hold > 0) in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || sum !== es || c_out !== ec || ovf !== eo
                || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold cycle %0d: got valid=%b sum=%h rdy=%b want 1 %h 0",
                         name, i, out_valid, sum, in_ready, es);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: got valid=%b in_ready=%b want 0 1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || c_out !== 1'b0
            || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: got rdy=%b valid=%b sum=%h c=%b v=%b want 1 0 0 0 0",
                     in_ready, out_valid, sum, c_out, ovf);
        end
    endtask

    task automatic test_directed();
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_byte_carry");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 0, "full_carry");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_ovf");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0, "sub_ovf");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, "sub_borrow");
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 0, "sub_equal");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0, "random");
        end
    endtask

    task automatic test_backpressure();
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 10, "backpressure");
    endtask

    task automatic test_reset_mid_run();
        a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; sub = 1'b0; c_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0
            || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_reset: got valid=%b sum=%h c=%b v=%b rdy=%b want 0 0 0 0 1",
                     out_valid, sum, c_out, ovf, in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_run_spurious cycle %0d: got valid=%b rdy=%b want 0 1",
                         i, out_valid, in_ready);
            end
        end
        run_op(32'hCAFE_0001, 32'h0000_FFFF, 1'b1, 1'b0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, "b2b_first");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, "b2b_second");
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 3, "b2b_third");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
